// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, state encoding and width helper for the
//                UART transmit arbiter and related UART glue logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_BYTE = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Width for an index/counter that must be at least one bit wide.
  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating priority encoder; returns the first
//                set request at or above the pointer, wrapping to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_ptr,
  output logic             o_found,
  output logic [GW-1:0]    o_idx
);

  logic [GW-1:0] w_pos;

  // Walk from the farthest offset down so the closest set bit wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_pos = GW'((int'(i_ptr) + i) % N_REQ);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin, packet-locked arbiter sharing the UART Avalon-MM
//                write port between byte-stream requesters, with idle eviction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADW     = 32,
  parameter int TIMEOUT = 1024,
  parameter int GW      = clog2_min1(N_REQ),
  parameter int TW      = clog2_min1(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [UART_BYTE*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     avalon_write,
  output logic [ADW-1:0]           avalon_writedata,
  input  logic                     avalon_waitrequest,
  output logic [GW-1:0]            gnt_id,
  output logic                     busy,
  output logic                     abort
);

  localparam bit            c_evict_en   = (TIMEOUT != 0);
  localparam logic [TW-1:0] c_timeout    = TW'(TIMEOUT);
  localparam logic [TW-1:0] c_timeout_m1 = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_gnt_id, w_gnt_nxt;
  logic [GW-1:0]   r_rr_ptr, w_ptr_nxt;
  logic [TW-1:0]   r_idle_cnt, w_cnt_nxt;
  logic            r_abort, w_abort_nxt;

  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic            w_write;
  logic            w_accept;
  logic            w_last;
  logic            w_timeout;
  logic [GW-1:0]   w_gnt_inc;
  logic [UART_BYTE-1:0] w_bytes [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lanes
    assign w_bytes[gi]   = req_data[UART_BYTE*gi +: UART_BYTE];
    assign req_ready[gi] = w_accept && (r_gnt_id == GW'(gi));
  end

  assign w_write   = (r_state == ST_LOCK) && req_valid[r_gnt_id];
  assign w_accept  = w_write && !avalon_waitrequest;
  assign w_last    = req_last[r_gnt_id];
  assign w_timeout = c_evict_en && (r_state == ST_LOCK) && !req_valid[r_gnt_id]
                     && (r_idle_cnt == c_timeout_m1);
  assign w_gnt_inc = (r_gnt_id == GW'(N_REQ - 1)) ? '0 : r_gnt_id + GW'(1);

  assign avalon_write     = w_write;
  assign avalon_writedata = {{(ADW-UART_BYTE){1'b0}}, w_bytes[r_gnt_id]};
  assign gnt_id           = r_gnt_id;
  assign busy             = (r_state == ST_LOCK);
  assign abort            = r_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '0;
      r_idle_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_idle_cnt <= w_cnt_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_id;
    w_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt   = r_idle_cnt;
    w_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_found) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // Counter saturates so a disabled or expired timer never wraps.
        if (w_write) begin
          w_cnt_nxt = '0;
        end else if (c_evict_en && (r_idle_cnt != c_timeout)) begin
          w_cnt_nxt = r_idle_cnt + TW'(1);
        end
        if (w_accept && w_last) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_gnt_inc;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_gnt_inc;
          w_abort_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the UART transmitter's Avalon-MM write port between N_REQ byte-stream requesters, such as a console, a debug dump and a status reporter. Arbitration is round-robin with packet lock: once granted, a requester keeps the transmitter until its byte flagged "last" is accepted, so messages never interleave on uart_txd. A stalled requester that holds the lock is evicted after a programmable idle timeout. The block sits directly in front of the uart module and is the only master of its write port.

Parameters:
N_REQ, 4, number of requesters (≥2)
ADW, 32, Avalon data width; must match the uart instance
TIMEOUT, 1024, idle cycles allowed mid-packet before eviction; 0 disables eviction
GW, $clog2(N_REQ), grant index width
TW, $clog2(TIMEOUT+1), idle counter width (minimum 1)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  N_REQ  per-requester byte valid
req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  N_REQ  byte is the last of its packet
req_ready  output  N_REQ  byte accepted this cycle
avalon_write  output  1  write strobe to uart
avalon_writedata  output  ADW  {zeros, granted byte}
avalon_waitrequest  input  1  uart busy (TX shift in progress)
gnt_id  output  GW  index of current owner; valid while busy=1
busy  output  1  a requester holds the lock
abort  output  1  one-cycle pulse when the owner is evicted by timeout

Behaviour:
- Reset is synchronous on the clk edge with rst=1. It forces state IDLE, rr_ptr=0, gnt_id=0, idle_cnt=0, busy=0 and abort=0. Because avalon_write and req_ready decode from state, both are 0 from the first cycle after reset.
- Reset mid-packet drops avalon_write immediately. A byte already accepted by the uart still completes on the line. The interrupted requester's packet is abandoned and no abort pulse is issued.
- Requester protocol: valid/ready. A requester holds valid and data stable until ready.
- Avalon rule: the arbiter asserts avalon_write only while the owner's req_valid=1, and passes data through combinationally. The stream protocol therefore keeps write and writedata stable across waitrequest.
- State IDLE: busy=0. If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap-around (N_REQ-1 → 0). Register gnt_id, then go to LOCK. The earliest write is one cycle after valid rises.
- State LOCK: busy=1.
  - avalon_write = req_valid[gnt_id].
  - accept = avalon_write & ~avalon_waitrequest.
  - req_ready[gnt_id] = accept; all other req_ready bits are 0.
- LOCK on accept with req_last=1: go to IDLE and set rr_ptr = gnt_id+1 mod N_REQ. IDLE lasts exactly one cycle before the next grant. This gap is negligible against the byte time.
- idle_cnt behaviour:
  - Cleared on entry to LOCK and whenever req_valid[gnt_id]=1.
  - Otherwise increments, saturating at TIMEOUT.
  - When idle_cnt==TIMEOUT-1 and req_valid[gnt_id]=0: go to IDLE, pulse abort for one cycle, set rr_ptr = gnt_id+1.
  - With TIMEOUT=0 the counter is held at 0 and eviction never occurs.
- Simultaneous events:
  - Accept of the last byte in the same cycle as a timeout cannot occur, because valid=1 clears the counter.
  - New requests arriving during LOCK wait.
  - A requester re-raising valid in the same cycle its last byte is accepted is not re-granted ahead of others; the pointer has already moved past it.
- Width: avalon_writedata[7:0] = granted byte, avalon_writedata[ADW-1:8] = 0.
- Throughput: at most one byte per uart frame. The uart's waitrequest paces all transfers; the arbiter adds no buffering.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants (ST_IDLE, ST_LOCK);
  - the UART_BYTE=8 constant;
  - the function clog2_min1 used for GW and TW.
- One sub-module, rr_pick:
  - inputs: N_REQ-bit request vector and GW-bit pointer;
  - outputs: found flag and GW-bit index;
  - purely combinational rotate-priority-encode.
- Reused by future RX dispatch logic.

Test Plan:
1. Single packet: requester 1 sends 0x41,0x42,0x43 (last on 0x43) with waitrequest toggled per byte → the three writes appear in order, writedata=0x00000041.., req_ready[1] pulses only on accepts, busy drops one cycle after 0x43 is accepted.
2. Round-robin: requesters 0, 2 and 3 each assert a one-byte packet in the same cycle from reset → grant order 0, 2, 3. A second round started by requester 3 with 0 and 2 pending → order 3, 0, 2 (pointer wrap from 3 to 0).
3. Lock/no-interleave: requester 0 sends a 4-byte packet while requester 1 is waiting → all 4 bytes of requester 0 are written before any byte of requester 1, and gnt_id stays 0 throughout.
4. Waitrequest stall: waitrequest held high for 50 cycles with write pending → avalon_write and writedata remain constant, req_ready=0, and exactly one accept occurs when waitrequest falls.
5. Timeout: TIMEOUT=8; requester 2 sends one byte without last, then drops valid → abort pulses once, 8 cycles after valid drops; busy=0; requester 3, already waiting, is granted next.
6. Reset mid-packet: rst asserted for one cycle while in LOCK with write pending → next cycle avalon_write=0, busy=0, abort=0, and the following grant starts from rr_ptr=0.
